// File: rtl/la_capture_reader_pkg.sv
// Shared widths, FSM encoding and stream beat payload for the capture readback path.
package la_capture_reader_pkg;

  localparam int unsigned LA_ADDR_W = 10;
  localparam int unsigned LA_DATA_W = 8;
  localparam int unsigned LA_DEPTH  = 1 << LA_ADDR_W;
  localparam int unsigned LA_CNT_W  = LA_ADDR_W + 1;
  localparam logic [LA_DATA_W-1:0] LA_HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } la_rd_state_t;

  typedef struct packed {
    logic                 last;
    logic [LA_DATA_W-1:0] data;
  } la_beat_t;

endpackage

// File: rtl/la_capture_reader_if.sv
// Valid/ready byte stream carrying the capture dump towards the CPU / UART path.
interface la_capture_reader_if;
  import la_capture_reader_pkg::*;

  logic [LA_DATA_W-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/la_capture_reader_ram.sv
// Private capture RAM: one write port, one synchronous read port with 1-cycle latency.
module la_capture_reader_ram
  import la_capture_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [LA_ADDR_W-1:0] waddr,
  input  logic [LA_DATA_W-1:0] wdata,
  input  logic                 re,
  input  logic [LA_ADDR_W-1:0] raddr,
  output logic [LA_DATA_W-1:0] rdata
);

  logic [LA_DATA_W-1:0] mem [LA_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_reader.sv
// Snoops the sample write port into a private RAM and drains it, oldest sample first,
// as a header byte plus DEPTH samples on a valid/ready stream.
module la_capture_reader
  import la_capture_reader_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 wr_en,
  input  logic [LA_ADDR_W-1:0] wr_addr,
  input  logic [LA_DATA_W-1:0] wr_data,
  input  logic [LA_ADDR_W-1:0] start_addr,
  input  logic                 finished,
  input  logic                 dump_req,
  la_capture_reader_if.master  m_axis,
  output logic                 busy,
  output logic                 capture_valid,
  output logic                 overrun
);

  la_rd_state_t state, state_nxt;

  logic                 fin_q, fin_rise;
  logic [LA_ADDR_W-1:0] base, rd_ptr, rd_addr;
  logic [LA_CNT_W-1:0]  cnt, issue_idx;
  logic                 rd_pend, rd_pend_last, rd_issue;
  logic [LA_DATA_W-1:0] ram_q;
  la_beat_t             s0, s1, s0_nxt, s1_nxt, push_beat;
  logic                 v0, v1, v0_nxt, v1_nxt, push;
  logic                 pop, last_pop, accept, streaming, ram_we;
  logic [1:0]           slots_used;

  assign pop      = v0 && m_axis.m_ready;
  assign last_pop = pop && s0.last;
  assign ram_we   = wr_en && !busy;
  assign fin_rise = finished && !fin_q;

  la_capture_reader_ram u_ram (
    .clk   (sys_clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dump_req && capture_valid) state_nxt = HDR;
      HDR:     if (pop) state_nxt = DATA;
      DATA:    if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    streaming = 1'b0;
    unique case (state)
      IDLE:    accept = dump_req && capture_valid;
      HDR:     streaming = 1'b1;
      DATA:    streaming = 1'b1;
      default: streaming = 1'b0;
    endcase
  end

  // Reads are issued only when the 2-entry skid can absorb them, counting the one in flight.
  assign slots_used = {1'b0, v0} + {1'b0, v1} + {1'b0, rd_pend};

  always_comb begin
    rd_issue  = 1'b0;
    rd_addr   = rd_ptr;
    issue_idx = cnt;
    if (accept) begin
      rd_issue  = 1'b1;
      rd_addr   = base;
      issue_idx = '0;
    end else if (streaming && (cnt != LA_CNT_W'(LA_DEPTH)) &&
                 ((slots_used < 2'd2) || ((slots_used == 2'd2) && pop))) begin
      rd_issue = 1'b1;
    end
  end

  // Skid as a shift register: s0 is always the presented beat.
  always_comb begin
    push      = accept || rd_pend;
    push_beat = accept ? la_beat_t'{last: 1'b0, data: LA_HDR_BYTE}
                       : la_beat_t'{last: rd_pend_last, data: ram_q};
    s0_nxt = s0;
    s1_nxt = s1;
    v0_nxt = v0;
    v1_nxt = v1;
    if (pop) begin
      s0_nxt = s1;
      v0_nxt = v1;
      v1_nxt = 1'b0;
    end
    if (push) begin
      if (!v0_nxt) begin
        s0_nxt = push_beat;
        v0_nxt = 1'b1;
      end else begin
        s1_nxt = push_beat;
        v1_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fin_q         <= 1'b0;
      base          <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      rd_pend       <= 1'b0;
      rd_pend_last  <= 1'b0;
      s0            <= '0;
      s1            <= '0;
      v0            <= 1'b0;
      v1            <= 1'b0;
      busy          <= 1'b0;
      capture_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      fin_q   <= finished;
      s0      <= s0_nxt;
      s1      <= s1_nxt;
      v0      <= v0_nxt;
      v1      <= v1_nxt;
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_ptr       <= rd_addr + LA_ADDR_W'(1);
        cnt          <= issue_idx + LA_CNT_W'(1);
        rd_pend_last <= (issue_idx == LA_CNT_W'(LA_DEPTH - 1));
      end
      if (accept)        busy <= 1'b1;
      else if (last_pop) busy <= 1'b0;
      if (accept)             overrun <= 1'b0;
      else if (busy && wr_en) overrun <= 1'b1;
      if (last_pop) begin
        capture_valid <= 1'b0;
      end else if (!busy && fin_rise) begin
        capture_valid <= 1'b1;
        base          <= start_addr;
      end else if (ram_we && !finished) begin
        capture_valid <= 1'b0;
      end
    end
  end

  assign m_axis.m_data  = s0.data;
  assign m_axis.m_last  = s0.last;
  assign m_axis.m_valid = v0;

endmodule

// File: tb/tb_la_capture_reader.sv
// Self-checking bench for la_capture_reader against an array model of the capture RAM.
module tb_la_capture_reader;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [9:0] start_addr;
  logic       finished;
  logic       dump_req;
  logic       busy, capture_valid, overrun;

  la_capture_reader_if axis ();

  la_capture_reader dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start_addr    (start_addr),
    .finished      (finished),
    .dump_req      (dump_req),
    .m_axis        (axis),
    .busy          (busy),
    .capture_valid (capture_valid),
    .overrun       (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_ram [1024];
  int         model_base;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load_capture(input bit identity, input logic [9:0] sa);
    finished = 1'b0;
    tick();
    for (int i = 0; i < 1024; i++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_data = identity ? 8'(i) : 8'($urandom);
      model_ram[i] = wr_data;
      tick();
    end
    wr_en      = 1'b0;
    start_addr = sa;
    finished   = 1'b1;
    tick();
    tick();
    model_base = int'(sa);
    checks++;
    if (capture_valid !== 1'b1) begin
      failures++;
      $display("FAIL load_capture_valid got=%b expected=1", capture_valid);
    end
  endtask

  // Runs one dump; stop_after<0 runs to completion, wr_at/fin_at inject events at a beat index.
  task automatic do_dump(input string tag, input int ready_pct, input int stop_after,
                         input int wr_at, input int fin_at);
    int beat = 0, cycles = 0, data_err = 0, last_err = 0, stab_err = 0, bubbles = 0;
    int bad_beat = -1;
    logic [7:0] bad_got = '0, bad_exp = '0, hold_data = '0, exp_d;
    logic hold = 1'b0, hold_last = 1'b0, done = 1'b0, exp_l, wr_fired = 1'b0;
    int fin_phase = 0;
    int wa;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    checks++;
    if (axis.m_valid !== 1'b1 || axis.m_data !== 8'hA5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_hdr valid=%b data=%h busy=%b expected valid=1 data=a5 busy=1",
               tag, axis.m_valid, axis.m_data, busy);
    end
    while (!done && beat != stop_after && cycles < 5000) begin
      if (hold && (axis.m_valid !== 1'b1 || axis.m_data !== hold_data ||
                   axis.m_last !== hold_last)) stab_err++;
      wr_en = 1'b0;
      if (wr_at >= 0 && beat >= wr_at && !wr_fired) begin
        wa       = (model_base + 600) % 1024;
        wr_en    = 1'b1;
        wr_addr  = 10'(wa);
        wr_data  = ~model_ram[wa];
        wr_fired = 1'b1;
      end
      if (fin_at >= 0 && fin_phase == 0 && beat >= fin_at) begin
        finished  = 1'b0;
        fin_phase = 1;
      end else if (fin_phase == 1 && beat >= fin_at + 10) begin
        finished   = 1'b1;
        start_addr = 10'($urandom);
        fin_phase  = 2;
      end
      axis.m_ready = ($urandom_range(99) < ready_pct);
      if (axis.m_valid === 1'b1 && axis.m_ready) begin
        exp_d = (beat == 0) ? 8'hA5 : model_ram[(model_base + beat - 1) % 1024];
        exp_l = (beat == 1024);
        if (axis.m_data !== exp_d) begin
          if (data_err == 0) begin
            bad_beat = beat;
            bad_got  = axis.m_data;
            bad_exp  = exp_d;
          end
          data_err++;
        end
        if (axis.m_last !== exp_l) last_err++;
        if (exp_l) done = 1'b1;
        beat++;
      end else if (ready_pct == 100) begin
        bubbles++;
      end
      hold      = (axis.m_valid === 1'b1) && !axis.m_ready;
      hold_data = axis.m_data;
      hold_last = axis.m_last;
      tick();
      cycles++;
    end
    axis.m_ready = 1'b0;
    wr_en        = 1'b0;
    checks++;
    if (data_err != 0) begin
      failures++;
      $display("FAIL %s_data errors=%0d first_beat=%0d got=%h expected=%h",
               tag, data_err, bad_beat, bad_got, bad_exp);
    end
    checks++;
    if (last_err != 0) begin
      failures++;
      $display("FAIL %s_last misplaced m_last count=%0d expected=0", tag, last_err);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL %s_stable changes_while_stalled=%0d expected=0", tag, stab_err);
    end
    if (stop_after < 0) begin
      checks++;
      if (!done || beat != 1025) begin
        failures++;
        $display("FAIL %s_beats got=%0d done=%b expected=1025 done=1", tag, beat, done);
      end
      if (ready_pct == 100) begin
        checks++;
        if (bubbles != 0) begin
          failures++;
          $display("FAIL %s_bubbles got=%0d expected=0", tag, bubbles);
        end
      end
      checks++;
      if (axis.m_valid !== 1'b0 || busy !== 1'b0 || capture_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_end valid=%b busy=%b cv=%b expected 0 0 0",
                 tag, axis.m_valid, busy, capture_valid);
      end
    end
  endtask

  task automatic expect_silence(input string tag);
    int seen = 0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (axis.m_valid !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s_no_response active_cycles=%0d expected=0", tag, seen);
    end
  endtask

  task automatic test_reset();
    sys_rst_n    = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    start_addr   = '0;
    finished     = 1'b0;
    dump_req     = 1'b0;
    axis.m_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({axis.m_valid, axis.m_last, busy, capture_valid, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags valid=%b last=%b busy=%b cv=%b ovr=%b expected all 0",
               axis.m_valid, axis.m_last, busy, capture_valid, overrun);
    end
    checks++;
    if (axis.m_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h expected=00", axis.m_data);
    end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_linear();
    load_capture(1'b1, 10'h000);
    do_dump("linear", 100, -1, -1, -1);
  endtask

  task automatic test_wrap();
    load_capture(1'b1, 10'h3F0);
    do_dump("wrap", 100, -1, -1, -1);
  endtask

  task automatic test_random_ready();
    load_capture(1'b1, 10'h3F0);
    do_dump("rready", 50, -1, -1, -1);
    load_capture(1'b0, 10'($urandom));
    do_dump("rdata", 70, -1, -1, -1);
  endtask

  task automatic test_no_capture_and_overrun();
    expect_silence("nocap");
    load_capture(1'b0, 10'($urandom));
    do_dump("ovr", 100, -1, 200, -1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b expected=1", overrun);
    end
    load_capture(1'b0, 10'($urandom));
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b expected=1", overrun);
    end
    do_dump("ovr2", 60, -1, -1, -1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b expected=0", overrun);
    end
  endtask

  task automatic test_reset_mid_dump();
    load_capture(1'b0, 10'($urandom));
    do_dump("abort", 100, 301, -1, -1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    checks++;
    if (axis.m_valid !== 1'b0 || busy !== 1'b0 || capture_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset valid=%b busy=%b cv=%b expected 0 0 0",
               axis.m_valid, busy, capture_valid);
    end
    load_capture(1'b0, 10'($urandom));
    do_dump("after_abort", 100, -1, -1, -1);
  endtask

  task automatic test_finish_while_busy();
    load_capture(1'b0, 10'($urandom));
    do_dump("finbusy", 100, -1, -1, 100);
    expect_silence("finbusy_after");
  endtask

  initial begin
    test_reset();
    test_linear();
    test_wrap();
    test_random_ready();
    test_no_capture_and_overrun();
    test_reset_mid_dump();
    test_finish_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
